// File: rtl/smg_scan.sv
// Multiplexed seven-segment scanner: one digit per clk_1khz rising edge, with a blanking
// gap between digits and a double-buffered frame so upstream updates never tear a frame.
module smg_scan #(
  parameter int DIGITS         = 6,
  parameter int BLANK_CYC      = 50,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_50MHz,
  input  logic                  rst,
  input  logic                  clk_1khz,
  input  logic [4*DIGITS-1:0]   disp_data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic                  data_valid,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [8:0] BLANK_END = 9'(BLANK_CYC);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state, state_nxt;
  logic                  s1, s2, s3;
  logic                  tick, wrap, copy;
  logic [IW-1:0]         idx, idx_nxt;
  logic [7:0]            cnt, cnt_nxt;

  logic [4*DIGITS-1:0]   act_data, pend_data, act_data_nxt;
  logic [DIGITS-1:0]     act_dp, pend_dp, act_dp_nxt;
  logic                  act_lz, pend_lz, act_lz_nxt, pend_flag;

  logic [DIGITS-1:0]     lz_mask;
  logic                  lead;
  logic [3:0]            code;
  logic                  dp_on, lit;
  logic [7:0]            seg_raw;
  logic [DIGITS-1:0]     sel_raw;

  // Segment pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] decode7(input logic [3:0] c);
    logic [6:0] p;
    case (c)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h40;
      4'hC: p = 7'h39;
      4'hD: p = 7'h79;
      4'hE: p = 7'h50;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  assign tick = s2 & ~s3;
  assign wrap = tick && (idx == LAST);
  assign copy = wrap && pend_flag;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (tick) begin
      // A tick in any state advances the digit and restarts the gap.
      idx_nxt   = (idx == LAST) ? '0 : idx + 1'b1;
      cnt_nxt   = '0;
      state_nxt = (BLANK_CYC == 0) ? SHOW : BLANK;
    end else if (state == BLANK) begin
      cnt_nxt = cnt + 8'd1;
      if (({1'b0, cnt} + 9'd1) >= BLANK_END) state_nxt = SHOW;
    end
  end

  always_comb begin
    act_data_nxt = copy ? pend_data : act_data;
    act_dp_nxt   = copy ? pend_dp   : act_dp;
    act_lz_nxt   = copy ? pend_lz   : act_lz;
  end

  // Leading-zero run from the leftmost digit; a dp on a zero ends the run.
  always_comb begin
    lz_mask = '0;
    lead    = act_lz_nxt;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (act_data_nxt[4*i +: 4] == 4'h0) && !act_dp_nxt[i]) lz_mask[i] = 1'b1;
      else lead = 1'b0;
    end
  end

  // Output stage is computed from next-cycle state so the registers line up with idx.
  always_comb begin
    code    = act_data_nxt[4*idx_nxt +: 4];
    dp_on   = act_dp_nxt[idx_nxt];
    lit     = (state_nxt == SHOW) && !lz_mask[idx_nxt];
    seg_raw = lit ? {dp_on, decode7(code)} : 8'h00;
    sel_raw = (state_nxt == SHOW) ? (DIGITS'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      idx        <= LAST;
      cnt        <= '0;
      frame_done <= 1'b0;
      act_data   <= {DIGITS{4'hB}};
      act_dp     <= '0;
      act_lz     <= 1'b0;
      pend_data  <= {DIGITS{4'hB}};
      pend_dp    <= '0;
      pend_lz    <= 1'b0;
      pend_flag  <= 1'b0;
      seg        <= {8{SEG_ACTIVE_LOW}};
      sel        <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      s1         <= clk_1khz;
      s2         <= s1;
      s3         <= s2;
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      frame_done <= wrap;
      act_data   <= act_data_nxt;
      act_dp     <= act_dp_nxt;
      act_lz     <= act_lz_nxt;
      if (data_valid) begin
        pend_data <= disp_data;
        pend_dp   <= dp_mask;
        pend_lz   <= blank_lz;
        pend_flag <= 1'b1;
      end else if (copy) begin
        pend_flag <= 1'b0;
      end
      seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      sel <= DIG_ACTIVE_LOW ? ~sel_raw : sel_raw;
    end
  end

endmodule

// File: tb/tb_smg_scan.sv
// Directed bench for smg_scan: a 50-cycle-gap instance and a zero-gap instance share stimulus.
module tb_smg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_1khz = 1'b0;
  logic        data_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic [23:0] disp_data = '0;
  logic [5:0]  dp_mask = '0;
  logic [7:0]  seg, seg0;
  logic [5:0]  sel, sel0;
  logic        frame_done, fd0;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int fd0_cnt  = 0;
  int pos      = 5;

  always #5 clk = ~clk;

  smg_scan #(.DIGITS(6), .BLANK_CYC(50), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk_50MHz(clk), .rst(rst), .clk_1khz(clk_1khz), .disp_data(disp_data),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .data_valid(data_valid),
    .seg(seg), .sel(sel), .frame_done(frame_done)
  );

  smg_scan #(.DIGITS(6), .BLANK_CYC(0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut0 (
    .clk_50MHz(clk), .rst(rst), .clk_1khz(clk_1khz), .disp_data(disp_data),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .data_valid(data_valid),
    .seg(seg0), .sel(sel0), .frame_done(fd0)
  );

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (fd0) fd0_cnt <= fd0_cnt + 1;
  end

  // One digit period, shortened to ~66 clocks; returns with both instances in SHOW.
  task automatic scan_tick();
    @(posedge clk); #1 clk_1khz = 1'b1;
    repeat (60) @(posedge clk);
    #1 clk_1khz = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    pos = (pos == 5) ? 0 : pos + 1;
  endtask

  // Same as scan_tick but strobes data_valid in the cycle the tick is seen.
  task automatic scan_tick_dv(input logic [23:0] d);
    @(posedge clk); #1 clk_1khz = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 disp_data = d; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
    repeat (57) @(posedge clk);
    #1 clk_1khz = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    pos = (pos == 5) ? 0 : pos + 1;
  endtask

  task automatic load(input logic [23:0] d, input logic [5:0] dp, input logic lz);
    @(posedge clk); #1 disp_data = d; dp_mask = dp; blank_lz = lz; data_valid = 1'b1;
    @(posedge clk); #1 data_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 4;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got %h want ff", seg); end
    if (sel !== 6'h3F) begin n_fail++; $display("FAIL reset_sel got %b want 111111", sel); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", frame_done); end
    if (sel0 !== 6'h3F) begin n_fail++; $display("FAIL reset_sel0 got %b want 111111", sel0); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (sel !== 6'h3F) begin n_fail++; $display("FAIL idle_sel got %b want 111111", sel); end
    if (seg0 !== 8'hFF) begin n_fail++; $display("FAIL idle_seg0 got %h want ff", seg0); end
    if (fd_cnt !== 0) begin n_fail++; $display("FAIL idle_fd got %0d want 0", fd_cnt); end
  endtask

  task automatic test_idle_scan();
    logic [5:0] es;
    int f0, want;
    for (int k = 0; k < 7; k++) begin
      f0 = fd_cnt;
      scan_tick();
      es = ~(6'b000001 << (k % 6));
      want = ((k % 6) == 0) ? 1 : 0;
      n_checks += 4;
      if (sel !== es) begin n_fail++; $display("FAIL walk_sel k=%0d got %b want %b", k, sel, es); end
      if (sel0 !== es) begin n_fail++; $display("FAIL walk_sel0 k=%0d got %b want %b", k, sel0, es); end
      if (seg !== 8'hFF) begin n_fail++; $display("FAIL walk_seg k=%0d got %h want ff", k, seg); end
      if (fd_cnt - f0 !== want) begin n_fail++; $display("FAIL walk_fd k=%0d got %0d want %0d", k, fd_cnt - f0, want); end
    end
  endtask

  task automatic test_decode();
    logic [7:0] exp [6];
    logic [5:0] es;
    exp = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    load(24'h012345, 6'b000000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      scan_tick();
      n_checks++;
      if (seg !== 8'hFF) begin n_fail++; $display("FAIL dec_old pos=%0d got %h want ff", pos, seg); end
    end
    for (int d = 0; d < 6; d++) begin
      scan_tick();
      es = ~(6'b000001 << d);
      n_checks += 3;
      if (sel !== es) begin n_fail++; $display("FAIL dec_sel d=%0d got %b want %b", d, sel, es); end
      if (seg !== exp[d]) begin n_fail++; $display("FAIL dec_seg d=%0d got %h want %h", d, seg, exp[d]); end
      if (seg0 !== exp[d]) begin n_fail++; $display("FAIL dec_seg0 d=%0d got %h want %h", d, seg0, exp[d]); end
    end
  endtask

  task automatic test_temp_format();
    logic [7:0] exp [6];
    exp = '{8'hC6, 8'hB0, 8'h12, 8'hA4, 8'hBF, 8'hFF};
    load(24'hBA253C, 6'b000100, 1'b0);
    for (int d = 0; d < 6; d++) begin
      scan_tick();
      n_checks++;
      if (seg !== exp[d]) begin n_fail++; $display("FAIL temp_seg d=%0d got %h want %h", d, seg, exp[d]); end
    end
  endtask

  task automatic test_leading_zeros();
    logic [23:0] dat [3];
    logic [5:0]  dpm [3];
    logic [7:0]  exp [3][6];
    dat = '{24'h000070, 24'h000000, 24'h000000};
    dpm = '{6'b000000, 6'b000000, 6'b000100};
    exp = '{'{8'hC0, 8'hF8, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
            '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
            '{8'hC0, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF}};
    for (int c = 0; c < 3; c++) begin
      load(dat[c], dpm[c], 1'b1);
      for (int d = 0; d < 6; d++) begin
        scan_tick();
        n_checks++;
        if (seg !== exp[c][d]) begin n_fail++; $display("FAIL lz_seg case=%0d d=%0d got %h want %h", c, d, seg, exp[c][d]); end
      end
    end
  endtask

  task automatic test_tear_free();
    int f0;
    load(24'h111111, 6'b000000, 1'b0);
    for (int d = 0; d < 6; d++) begin
      scan_tick();
      n_checks++;
      if (seg !== 8'hF9) begin n_fail++; $display("FAIL tear_old d=%0d got %h want f9", d, seg); end
      if (d == 3) load(24'h222222, 6'b000000, 1'b0);
    end
    f0 = fd_cnt;
    scan_tick();
    n_checks += 2;
    if (seg !== 8'hA4) begin n_fail++; $display("FAIL tear_new got %h want a4", seg); end
    if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL tear_fd got %0d want 1", fd_cnt - f0); end
    repeat (5) scan_tick();
    load(24'h333333, 6'b000000, 1'b0);
    scan_tick_dv(24'h444444);
    n_checks += 2;
    if (seg !== 8'hB0) begin n_fail++; $display("FAIL coinc_first got %h want b0", seg); end
    if (sel !== 6'b111110) begin n_fail++; $display("FAIL coinc_sel got %b want 111110", sel); end
    repeat (5) scan_tick();
    n_checks++;
    if (seg !== 8'hB0) begin n_fail++; $display("FAIL coinc_hold got %h want b0", seg); end
    scan_tick();
    n_checks += 2;
    if (seg !== 8'h99) begin n_fail++; $display("FAIL coinc_next got %h want 99", seg); end
    if (seg0 !== 8'h99) begin n_fail++; $display("FAIL coinc_next0 got %h want 99", seg0); end
  endtask

  task automatic test_blank_gap();
    int first_off = -1, first_on = -1, first0 = -1;
    logic [7:0] seg_mid = 8'h00;
    @(posedge clk); #1 clk_1khz = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (first_off < 0 && sel === 6'h3F) first_off = c;
      if (first_on < 0 && first_off >= 0 && sel === 6'b111101) first_on = c;
      if (first0 < 0 && sel0 === 6'b111101) first0 = c;
      if (c == 30) seg_mid = seg;
    end
    @(posedge clk); #1 clk_1khz = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    pos = 1;
    n_checks += 5;
    if (first_off !== 3) begin n_fail++; $display("FAIL gap_start got %0d want 3", first_off); end
    if (first_on - 2 !== 51) begin n_fail++; $display("FAIL gap_50 got %0d want 51", first_on - 2); end
    if (first0 - 2 !== 1) begin n_fail++; $display("FAIL gap_0 got %0d want 1", first0 - 2); end
    if (seg_mid !== 8'hFF) begin n_fail++; $display("FAIL gap_seg got %h want ff", seg_mid); end
    if (seg !== 8'h99) begin n_fail++; $display("FAIL gap_show got %h want 99", seg); end
  endtask

  task automatic test_rst_mid_scan();
    int f0;
    load(24'h888888, 6'b111111, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    pos = 5;
    n_checks += 4;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL rst_seg got %h want ff", seg); end
    if (sel !== 6'h3F) begin n_fail++; $display("FAIL rst_sel got %b want 111111", sel); end
    if (seg0 !== 8'hFF) begin n_fail++; $display("FAIL rst_seg0 got %h want ff", seg0); end
    if (sel0 !== 6'h3F) begin n_fail++; $display("FAIL rst_sel0 got %b want 111111", sel0); end
    f0 = fd_cnt;
    scan_tick();
    n_checks += 3;
    if (sel !== 6'b111110) begin n_fail++; $display("FAIL rst_first_sel got %b want 111110", sel); end
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL rst_lost got %h want ff", seg); end
    if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL rst_fd got %0d want 1", fd_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_decode();
    test_temp_format();
    test_leading_zeros();
    test_tear_free();
    test_blank_gap();
    test_rst_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/smg_scan.md
# smg_scan

Multiplexed seven-segment display scanner for the temperature readout. It samples the free-running 1 kHz square wave `clk_1khz` in the `clk_50MHz` domain and advances one digit per rising edge. For each digit it decodes a 4-bit code into segment drives, with a ghost-suppression blanking gap between digits. Display data is double-buffered so the upstream formatter can update at any time without tearing a frame.

## Interface
- `DIGITS`, 6: number of digits (2..8).
- `BLANK_CYC`, 50: `clk_50MHz` cycles of all-off between digits (0..255; 0 = no gap).
- `SEG_ACTIVE_LOW`, 1: 1 = segment lines driven low when lit.
- `DIG_ACTIVE_LOW`, 1: 1 = digit select driven low when enabled.

Ports:
- `clk_50MHz` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `clk_1khz` in 1: scan rate square wave from the clock divider; treated as asynchronous.
- `disp_data` in 4*DIGITS: digit codes, nibble 0 = rightmost digit.
- `dp_mask` in DIGITS: decimal point per digit, bit 0 = rightmost.
- `blank_lz` in 1: enable leading-zero blanking, sampled with `data_valid`.
- `data_valid` in 1: one-cycle strobe that captures `disp_data`, `dp_mask` and `blank_lz` into the pending buffer.
- `seg` out 8: {dp,g,f,e,d,c,b,a}, registered.
- `sel` out DIGITS: one-hot digit enable, registered.
- `frame_done` out 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Input synchronization:** `clk_1khz` passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. `tick = s2 & ~s3`.
- **Digit codes:** 0–9 are decimal. 0xA = '-' (g only). 0xB = blank. 0xC = 'C' (a,d,e,f). 0xD = 'E' (a,d,e,f,g). 0xE = 'r' (e,g). 0xF = blank.
- **dp:** lit iff the `dp_mask` bit of the current digit is 1, regardless of code.
- **Leading-zero blanking** (when the active `blank_lz` = 1):
  - Scanning from digit DIGITS-1 downward, each code-0 digit is blanked until the first digit that has a nonzero code or dp set.
  - Digit 0 is never blanked.
  - A blanked digit also suppresses its dp.
- **Buffers:**
  - `data_valid` writes the pending buffer and sets `pend_flag`.
  - When `idx` wraps to 0 with `pend_flag` = 1, pending is copied to active and `pend_flag` clears.
  - If `data_valid` arrives in the same cycle as the copy, active receives the old pending value, pending takes the new data, and `pend_flag` stays 1.
- **FSM states:** IDLE, BLANK, SHOW.
  - IDLE → BLANK on `tick`.
  - BLANK → SHOW when the blank counter reaches BLANK_CYC.
  - SHOW → BLANK on `tick`.
  - A `tick` while in BLANK increments `idx` again and restarts the counter.
- **Digit index:** on every `tick`, `idx` = (`idx` == DIGITS-1) ? 0 : `idx`+1. On wrap, `frame_done` = 1 for one cycle.
- **Polarity:** `seg` and `sel` are inverted per SEG_ACTIVE_LOW / DIG_ACTIVE_LOW at the output registers. "Off" always means the inactive level.

## Timing
- **Reset values:**
  - `seg` = all off, `sel` = all off, `frame_done` = 0.
  - FSM = IDLE, `idx` = DIGITS-1, blank counter = 0.
  - s1/s2/s3 = 0.
  - Active buffer = all 0xB, dp 0, `blank_lz` 0.
  - Pending buffer = all 0xB, `pend_flag` = 0.
- **Tick latency:** `tick` is high in cycle T, 2–3 cycles after the `clk_1khz` rising edge.
- **Cycle T+1:**
  - `sel` and `seg` all off.
  - `idx` holds the new value.
  - `frame_done` is high if `idx` wrapped.
  - The buffer copy has occurred if `idx` wrapped.
- **Cycle T+1+BLANK_CYC:** `sel` asserts the new `idx` and `seg` shows its decoded value. With BLANK_CYC = 0 this happens at T+1.
- **Holding:** `sel`/`seg` track the active buffer combinationally-then-registered (1-cycle delay) while in SHOW. The active buffer changes only at wrap.
- **First tick after reset:** wraps to digit 0, so digit 0 is displayed first.
- **`rst` mid-scan:** all outputs off in the next cycle; pending data is lost.
- **Scan rate:** nominal 1 kHz gives a 1 ms digit period and a DIGITS ms frame.

## Test plan
- **Reset then 1 kHz (DIGITS=6, BLANK_CYC=50):**
  - Stimulus: no `data_valid`.
  - Expect: `seg` stays all-off (0xFF, active-low) on every digit.
  - Expect: `sel` walks 111110→111101→…→011111→111110.
  - Expect: `frame_done` every 6th tick.
- **Decode:**
  - Stimulus: `data_valid` with `disp_data` = 0x012345, `dp_mask` = 0.
  - Expect: starting the next frame, digit 0 `seg` = ~0x6D ('5') and digit 5 `seg` = ~0x3F ('0').
- **Temperature format:**
  - Stimulus: `disp_data` = 0xBA253C (blank, '-', 2, 5, 3, 'C'), `dp_mask` = 0b000100, `blank_lz` = 0.
  - Expect: digit 2 shows '5' with dp, i.e. `seg` = ~0xED.
- **Leading zeros:**
  - Stimulus: `disp_data` = 0x000070, `blank_lz` = 1.
  - Expect: digits 5..2 all-off, digit 1 = '7', digit 0 = '0'.
  - Stimulus: `disp_data` = 0x000000.
  - Expect: only digit 0 lit.
- **Tear-free update:**
  - Stimulus: `data_valid` mid-frame while digit 3 is showing.
  - Expect: digits 2..0 keep the old data; the new data appears only after the next `frame_done`.
  - Stimulus: `data_valid` coincident with wrap.
  - Expect: the old pending value goes live and the new value goes live one frame later.
- **Blank gap:**
  - Measure from `tick` to `sel` asserted.
  - Expect: exactly 51 cycles with BLANK_CYC=50, and 1 cycle with BLANK_CYC=0.
  - Stimulus: `rst` pulse during SHOW.
  - Expect: all off next cycle, and the next tick selects digit 0.
